// File: rtl/count_uart_tx.sv
// Hex-character UART transmitter for 4-bit counter samples.
// One-deep holding register in front of an 8N1 serializer, optional trailing line feed.
module count_uart_tx #(
  parameter int unsigned CLKS_PER_BIT   = 104,
  parameter bit          APPEND_NEWLINE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] BaudMax = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q;
  logic            hold_full_q;
  logic [3:0]      hold_data_q;
  logic [7:0]      shift_q;
  logic [2:0]      bit_cnt_q;
  logic [CntW-1:0] baud_cnt_q;
  logic            second_q;
  logic            tx_q;
  logic            busy_q;
  logic            overrun_q;

  function automatic logic [7:0] to_ascii(input logic [3:0] v);
    if (v < 4'd10) return 8'h30 + {4'h0, v};
    else           return 8'h37 + {4'h0, v};
  endfunction

  assign data_ready = ~hold_full_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      hold_full_q <= 1'b0;
      hold_data_q <= 4'h0;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      baud_cnt_q  <= '0;
      second_q    <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // Holder is cleared only in StIdle while full, so accept never collides with it.
      if (data_valid) begin
        if (!hold_full_q) begin
          hold_full_q <= 1'b1;
          hold_data_q <= data_in;
        end else begin
          overrun_q <= 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (hold_full_q) begin
            shift_q     <= to_ascii(hold_data_q);
            hold_full_q <= 1'b0;
            second_q    <= 1'b0;
            baud_cnt_q  <= '0;
            state_q     <= StStart;
            tx_q        <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        StStart: begin
          if (baud_cnt_q == BaudMax) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= 3'd0;
            tx_q       <= shift_q[0];
            state_q    <= StData;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        StData: begin
          if (baud_cnt_q == BaudMax) begin
            baud_cnt_q <= '0;
            if (bit_cnt_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (baud_cnt_q == BaudMax) begin
            baud_cnt_q <= '0;
            if (APPEND_NEWLINE && !second_q) begin
              // Line feed follows the hex char with no idle gap.
              second_q <= 1'b1;
              shift_q  <= 8'h0A;
              tx_q     <= 1'b0;
              state_q  <= StStart;
            end else begin
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_count_uart_tx.sv
// Self-checking bench for count_uart_tx: three instances with different bit periods and
// newline settings, line waveforms checked against frames built from the expected characters.
module tb_count_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] data_in = 4'h0;
  logic       data_valid = 1'b0;
  logic [2:0] tx_w, busy_w, ready_w, ovr_w;

  int    sel = 0;
  int    cyc = 0;
  int    cnt_base = 0;
  bit    cnt_mode = 1'b0;
  int    errors = 0;
  int    checks = 0;
  string hex = "0123456789ABCDEF";

  logic tx_m, busy_m, ready_m, ovr_m;
  assign tx_m    = tx_w[sel];
  assign busy_m  = busy_w[sel];
  assign ready_m = ready_w[sel];
  assign ovr_m   = ovr_w[sel];

  always #5 clk = ~clk;

  count_uart_tx #(.CLKS_PER_BIT(4), .APPEND_NEWLINE(1'b0)) u_c4_nl0 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .overrun(ovr_w[0])
  );
  count_uart_tx #(.CLKS_PER_BIT(4), .APPEND_NEWLINE(1'b1)) u_c4_nl1 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .overrun(ovr_w[1])
  );
  count_uart_tx #(.CLKS_PER_BIT(2), .APPEND_NEWLINE(1'b0)) u_c2_nl0 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .overrun(ovr_w[2])
  );

  // In counter mode data_in follows the edge count; otherwise a valid lasts one edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cnt_mode) data_in = 4'(cyc - cnt_base);
    else          data_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int s);
    cnt_mode   = 1'b0;
    data_valid = 1'b0;
    reset      = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sel   = s;
  endtask

  task automatic offer(input logic [3:0] v);
    data_in    = v;
    data_valid = 1'b1;
  endtask

  // Called in the first cycle of a start bit; returns in the cycle after the stop bit.
  task automatic frame(input int cpb, input logic [7:0] ch, input string tag);
    logic [9:0] bits;
    logic [7:0] obs, bz, mask;
    bits = {1'b1, ch, 1'b0};
    mask = 8'((1 << cpb) - 1);
    for (int b = 0; b < 10; b++) begin
      obs = '0;
      bz  = '0;
      for (int k = 0; k < cpb; k++) begin
        obs[k] = tx_m;
        bz[k]  = busy_m;
        tick();
      end
      chk($sformatf("%s tx bit%0d", tag, b), obs, bits[b] ? mask : 8'h00);
      chk($sformatf("%s busy bit%0d", tag, b), bz, mask);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " idle tx"}, 8'(tx_m), 8'h01);
    chk({tag, " idle busy"}, 8'(busy_m), 8'h00);
  endtask

  initial begin
    logic [3:0] v;
    int         n;
    int         gap;

    // 1: reset state, single 0x3, no newline
    do_reset(0);
    chk("rst tx", 8'(tx_m), 8'h01);
    chk("rst busy", 8'(busy_m), 8'h00);
    chk("rst ready", 8'(ready_m), 8'h01);
    chk("rst overrun", 8'(ovr_m), 8'h00);
    offer(4'h3);
    tick();
    chk("t1 ready after accept", 8'(ready_m), 8'h00);
    chk("t1 tx before start", 8'(tx_m), 8'h01);
    tick();
    chk("t1 ready at start", 8'(ready_m), 8'h01);
    frame(4, hex[3], "t1 char");
    chk_idle("t1");

    // 2: 0xA with line feed, no gap between frames
    do_reset(1);
    offer(4'hA);
    tick();
    tick();
    frame(4, hex[10], "t2 char");
    frame(4, 8'h0A, "t2 lf");
    chk_idle("t2");

    // 3: continuous counter-driven offers; only the holder slots are accepted
    do_reset(1);
    cnt_base   = cyc;
    cnt_mode   = 1'b1;
    data_in    = 4'h0;
    data_valid = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      n = (k == 0) ? 0 : 2 + (k - 1) * 81;
      frame(4, hex[n % 16], $sformatf("t3 s%0d", k));
      frame(4, 8'h0A, $sformatf("t3 lf%0d", k));
      chk_idle($sformatf("t3 s%0d", k));
      chk("t3 overrun", 8'(ovr_m), 8'h01);
      tick();
    end
    cnt_mode   = 1'b0;
    data_valid = 1'b0;

    // 4: 0xF then 0x0 accepted mid-frame, one idle cycle between
    do_reset(0);
    offer(4'hF);
    tick();
    tick();
    offer(4'h0);
    frame(4, hex[15], "t4 first");
    chk_idle("t4");
    chk("t4 ready held", 8'(ready_m), 8'h00);
    tick();
    frame(4, hex[0], "t4 second");
    chk_idle("t4 end");
    chk("t4 overrun", 8'(ovr_m), 8'h00);

    // 5: asynchronous reset in the middle of 0x7's data bits
    do_reset(1);
    offer(4'h7);
    tick();
    tick();
    offer(4'h5);
    tick();
    offer(4'h5);
    tick();
    chk("t5 overrun set", 8'(ovr_m), 8'h01);
    for (int i = 0; i < 16; i++) tick();
    chk("t5 tx bit3 low", 8'(tx_m), 8'h00);
    #2 reset = 1'b1;
    #1;
    chk("t5 async tx", 8'(tx_m), 8'h01);
    chk("t5 async busy", 8'(busy_m), 8'h00);
    chk("t5 async ready", 8'(ready_m), 8'h01);
    chk("t5 async overrun", 8'(ovr_m), 8'h00);
    tick();
    reset = 1'b0;
    tick();
    offer(4'h9);
    tick();
    tick();
    frame(4, hex[9], "t5 char");
    frame(4, 8'h0A, "t5 lf");
    chk_idle("t5");
    for (int i = 0; i < 3; i++) tick();
    chk_idle("t5 quiet");

    // random values with random gaps, newline instance
    do_reset(1);
    for (int k = 0; k < 4; k++) begin
      gap = int'($urandom_range(3));
      for (int i = 0; i < gap; i++) tick();
      v = 4'($urandom_range(15));
      offer(v);
      tick();
      tick();
      frame(4, hex[v], $sformatf("rnd%0d char", k));
      frame(4, 8'h0A, $sformatf("rnd%0d lf", k));
      chk_idle($sformatf("rnd%0d", k));
    end
    chk("rnd overrun", 8'(ovr_m), 8'h00);

    // 6: minimum bit period, all 16 values in order
    do_reset(2);
    for (int k = 0; k < 16; k++) begin
      offer(4'(k));
      tick();
      tick();
      frame(2, hex[k], $sformatf("t6 v%0d", k));
      chk_idle($sformatf("t6 v%0d", k));
    end
    chk("t6 overrun", 8'(ovr_m), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
